// File: rtl/link_order_arbiter_pkg.sv
// link_pkg: shared types and constants for the link_top order arbiter.
//   APPE/DELE/CHAG/READ : order type encodings understood by link_top
//   order_t             : one captured order {typ, tbl, node, data}
//   arb_state_t         : arbiter FSM states
package link_pkg;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int TABLE_W = 8;

   localparam logic [1:0] APPE = 2'b00;
   localparam logic [1:0] DELE = 2'b01;
   localparam logic [1:0] CHAG = 2'b10;
   localparam logic [1:0] READ = 2'b11;

   typedef struct packed {
      logic [1:0]         typ;
      logic [TABLE_W-1:0] tbl;
      logic [ADDR_W-1:0]  node;
      logic [DATA_W-1:0]  data;
   } order_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/link_order_arbiter_if.sv
// link_order_if: the link_top side of the arbiter (order port + dout port).
//   order_valid/busy + order_type/table/node/data : order issued to link_top
//   dout_valid/busy + dout_data                   : READ result from link_top
//   master modport = arbiter, slave modport = link_top.
interface link_order_if
   import link_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_W,
   parameter int DATA_WIDTH  = DATA_W,
   parameter int TABLE_WIDTH = TABLE_W
);
   logic                   order_valid;
   logic                   order_busy;
   logic [1:0]             order_type;
   logic [TABLE_WIDTH-1:0] order_table;
   logic [ADDR_WIDTH-1:0]  order_node;
   logic [DATA_WIDTH-1:0]  order_data;
   logic                   dout_valid;
   logic                   dout_busy;
   logic [DATA_WIDTH-1:0]  dout_data;

   modport master (
      output order_valid, order_type, order_table, order_node, order_data, dout_busy,
      input  order_busy, dout_valid, dout_data
   );

   modport slave (
      input  order_valid, order_type, order_table, order_node, order_data, dout_busy,
      output order_busy, dout_valid, dout_data
   );
endinterface

// File: rtl/link_order_arbiter_rr_arb.sv
// link_rr_arb: combinational round-robin grant.
//   i_req : request vector
//   i_ptr : highest-priority requester this cycle
//   o_gnt : one-hot grant (all zero when no request)
//   o_idx : index of the granted requester
//   o_any : at least one request present
module link_rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   // ptr+k never exceeds 2N-2, so one conditional subtract wraps it
   function automatic logic [PW-1:0] wrap(input int a);
      int b;
      b = (a >= N) ? a - N : a;
      return PW'(b);
   endfunction

   logic w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && i_req[wrap(int'(i_ptr) + k)]) begin
            w_found                       = 1'b1;
            o_gnt[wrap(int'(i_ptr) + k)]  = 1'b1;
            o_idx                         = wrap(int'(i_ptr) + k);
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/link_order_arbiter.sv
// link_order_arbiter: shares link_top's single order port among NUM_REQ
// requesters (round-robin), one order in flight, and routes READ results
// back to the requester that issued the READ.
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : per-requester order handshake + packed payloads
//   resp_*            : per-requester READ result (shared data bus)
//   lnk               : order/dout ports toward link_top (master side)
//   err_unexpected    : sticky, dout_valid seen with no READ pending
module link_order_arbiter
   import link_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_WIDTH  = ADDR_W,
   parameter int DATA_WIDTH  = DATA_W,
   parameter int TABLE_WIDTH = TABLE_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_busy,
   input  logic [2*NUM_REQ-1:0]           req_type,
   input  logic [TABLE_WIDTH*NUM_REQ-1:0] req_table,
   input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_node,
   input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]             resp_valid,
   input  logic [NUM_REQ-1:0]             resp_busy,
   output logic [DATA_WIDTH-1:0]          resp_data,
   link_order_if.master                   lnk,
   output logic                           err_unexpected
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         r_state, w_state_nxt;
   logic [PW-1:0]      r_rr_ptr, r_grant_idx;
   order_t             r_order, w_req_order;
   logic               r_order_valid;
   logic               r_err;
   logic [NUM_REQ-1:0] w_gnt;
   logic [PW-1:0]      w_gnt_idx;
   logic               w_any;
   logic               w_dout_busy;

   link_rr_arb #(.N(NUM_REQ), .PW(PW)) u_rr (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_any)
   );

   // payload of the current round-robin winner
   always_comb begin
      w_req_order      = '0;
      w_req_order.typ  = req_type[2*int'(w_gnt_idx) +: 2];
      w_req_order.tbl  = req_table[TABLE_WIDTH*int'(w_gnt_idx) +: TABLE_WIDTH];
      w_req_order.node = req_node[ADDR_WIDTH*int'(w_gnt_idx) +: ADDR_WIDTH];
      w_req_order.data = req_data[DATA_WIDTH*int'(w_gnt_idx) +: DATA_WIDTH];
   end

   // next state + combinational handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      req_busy    = '1;
      resp_valid  = '0;
      resp_data   = '0;
      w_dout_busy = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               req_busy    = ~w_gnt;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!lnk.order_busy)
               w_state_nxt = (r_order.typ == READ) ? WAIT_RD : IDLE;
         end
         WAIT_RD: begin
            // straight passthrough to the requester that issued the READ
            resp_valid[r_grant_idx] = lnk.dout_valid;
            resp_data               = lnk.dout_data;
            w_dout_busy             = resp_busy[r_grant_idx];
            if (lnk.dout_valid && !resp_busy[r_grant_idx])
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_rr_ptr      <= '0;
         r_grant_idx   <= '0;
         r_order       <= '0;
         r_order_valid <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_any) begin
            r_order       <= w_req_order;
            r_grant_idx   <= w_gnt_idx;
            r_rr_ptr      <= (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
            r_order_valid <= 1'b1;
         end
         if (r_state == ISSUE && !lnk.order_busy)
            r_order_valid <= 1'b0;
         // outside WAIT_RD dout is accepted (busy=0) and dropped
         if (lnk.dout_valid && r_state != WAIT_RD)
            r_err <= 1'b1;
      end
   end

   assign lnk.order_valid = r_order_valid;
   assign lnk.order_type  = r_order.typ;
   assign lnk.order_table = r_order.tbl;
   assign lnk.order_node  = r_order.node;
   assign lnk.order_data  = r_order.data;
   assign lnk.dout_busy   = w_dout_busy;
   assign err_unexpected  = r_err;

endmodule

// File: tb/tb_link_order_arbiter.sv
// Self-checking bench for link_order_arbiter: transaction-level model of the
// arbiter and of link_top, directed scenarios plus randomized traffic.
module tb_link_order_arbiter;
   import link_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid, req_busy, resp_valid, resp_busy;
   logic [2*N-1:0]  req_type;
   logic [8*N-1:0]  req_table;
   logic [16*N-1:0] req_node, req_data;
   logic [15:0]   resp_data;
   logic          err;

   link_order_if lnk_if ();

   link_order_arbiter #(.NUM_REQ(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_busy       (req_busy),
      .req_type       (req_type),
      .req_table      (req_table),
      .req_node       (req_node),
      .req_data       (req_data),
      .resp_valid     (resp_valid),
      .resp_busy      (resp_busy),
      .resp_data      (resp_data),
      .lnk            (lnk_if),
      .err_unexpected (err)
   );

   always #5 clk = ~clk;

   // requester-side pending orders (held until granted)
   bit          p_v  [N];
   logic [1:0]  p_t  [N];
   logic [7:0]  p_tb [N];
   logic [15:0] p_n  [N];
   logic [15:0] p_d  [N];

   // knobs
   bit          ob, spur;
   logic [N-1:0] rb;
   int          rd_delay;
   logic [15:0] rd_data;

   // link_top model: one outstanding READ result
   bit          lk_pend;
   int          lk_cnt;
   logic [15:0] lk_data;

   // arbiter model: 0 = free, 1 = order offered to link_top, 2 = awaiting READ data
   int          m_phase, m_ptr, m_gidx;
   logic [1:0]  m_t;
   logic [7:0]  m_tb;
   logic [15:0] m_n, m_d;
   bit          m_err;
   int          grant_log[$];
   int          grant_cyc[$];
   int          cyc_n;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
   endtask

   function automatic int winner(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_gidx = 0;
      m_t = '0; m_tb = '0; m_n = '0; m_d = '0; m_err = 0;
      lk_pend = 0;
   endtask

   task automatic set_req(input int i, input logic [1:0] t, input logic [7:0] tb_,
                          input logic [15:0] n, input logic [15:0] d);
      p_v[i] = 1; p_t[i] = t; p_tb[i] = tb_; p_n[i] = n; p_d[i] = d;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = p_v[i];
         req_type[2*i +: 2]     = p_t[i];
         req_table[8*i +: 8]    = p_tb[i];
         req_node[16*i +: 16]   = p_n[i];
         req_data[16*i +: 16]   = p_d[i];
      end
      lnk_if.order_busy = ob;
      resp_busy         = rb;
      lnk_if.dout_valid = (lk_pend && lk_cnt == 0) || spur;
      lnk_if.dout_data  = lk_pend ? lk_data : 16'($urandom);
   endtask

   task automatic check_model();
      int w;
      logic [N-1:0] e_busy, e_rv;
      #1;
      w = (m_phase == 0) ? winner(req_valid, m_ptr) : -1;
      e_busy = '1;
      if (w >= 0) e_busy[w] = 1'b0;
      e_rv = '0;
      if (m_phase == 2 && lnk_if.dout_valid) e_rv[m_gidx] = 1'b1;
      chk("req_busy",    req_busy, e_busy);
      chk("order_valid", lnk_if.order_valid, m_phase == 1);
      chk("order_type",  lnk_if.order_type, m_t);
      chk("order_table", lnk_if.order_table, m_tb);
      chk("order_node",  lnk_if.order_node, m_n);
      chk("order_data",  lnk_if.order_data, m_d);
      chk("resp_valid",  resp_valid, e_rv);
      chk("resp_data",   resp_data, (m_phase == 2) ? lnk_if.dout_data : 16'h0);
      chk("dout_busy",   lnk_if.dout_busy, (m_phase == 2) ? rb[m_gidx] : 1'b0);
      chk("err",         err, m_err);
   endtask

   task automatic step();
      int w;
      bit dvv, dbusy;
      if (rst) model_reset();
      else begin
         dvv   = lnk_if.dout_valid;
         dbusy = (m_phase == 2) ? rb[m_gidx] : 1'b0;
         if (dvv && m_phase != 2) m_err = 1;
         if (lk_pend && dvv && !dbusy && m_phase == 2) lk_pend = 0;
         else if (lk_pend && lk_cnt > 0) lk_cnt--;
         case (m_phase)
            0: begin
               w = winner(req_valid, m_ptr);
               if (w >= 0) begin
                  m_t = p_t[w]; m_tb = p_tb[w]; m_n = p_n[w]; m_d = p_d[w];
                  m_gidx = w; m_ptr = (w + 1) % N; p_v[w] = 0;
                  grant_log.push_back(w); grant_cyc.push_back(cyc_n);
                  m_phase = 1;
               end
            end
            1: if (!ob) begin
               if (m_t == 2'b11) begin
                  lk_pend = 1; lk_cnt = rd_delay; lk_data = rd_data; m_phase = 2;
               end else m_phase = 0;
            end
            default: if (dvv && !rb[m_gidx]) m_phase = 0;
         endcase
      end
      spur = 0;
      @(posedge clk);
      cyc_n++;
      #1;
   endtask

   task automatic cyc_pre();
      @(negedge clk);
      drive();
      check_model();
   endtask

   task automatic cycle();
      cyc_pre();
      step();
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         if (!p_v[0] && !p_v[1] && !p_v[2] && !p_v[3] && m_phase == 0 && !lk_pend) done = 1;
         else cycle();
      end
      chk(name, done, 1'b1);
   endtask

   initial begin
      rst = 1; ob = 0; spur = 0; rb = '0; rd_delay = 0; rd_data = '0; cyc_n = 0;
      for (int i = 0; i < N; i++) begin
         p_v[i] = 0; p_t[i] = '0; p_tb[i] = '0; p_n[i] = '0; p_d[i] = '0;
      end
      model_reset();
      drive();
      @(posedge clk); #1;
      cycle(); cycle();
      rst = 0;
      chk("rst_req_busy", req_busy, 4'hF);
      chk("rst_ovalid", lnk_if.order_valid, 1'b0);
      chk("rst_err", err, 1'b0);

      // single APPE from requester 0
      set_req(0, APPE, 8'd3, 16'd1, 16'd111);
      cyc_pre();
      chk("t1_accept_busy", req_busy, 4'b1110);
      step();
      chk("t1_ovalid", lnk_if.order_valid, 1'b1);
      chk("t1_type", lnk_if.order_type, 2'b00);
      chk("t1_table", lnk_if.order_table, 8'd3);
      chk("t1_node", lnk_if.order_node, 16'd1);
      chk("t1_data", lnk_if.order_data, 16'd111);
      cycle();
      chk("t1_ovalid_drop", lnk_if.order_valid, 1'b0);

      // all four at once from a fresh pointer
      rst = 1; cycle(); rst = 0;
      grant_log.delete(); grant_cyc.delete();
      for (int i = 0; i < N; i++) set_req(i, APPE, 8'd0, 16'd0, 16'(10 + i));
      drain("t2_drain");
      chk("t2_n", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         chk("t2_g0", grant_log[0], 0);
         chk("t2_g1", grant_log[1], 1);
         chk("t2_g2", grant_log[2], 2);
         chk("t2_g3", grant_log[3], 3);
         chk("t2_spacing", grant_cyc[3] - grant_cyc[0], 6);
      end
      grant_log.delete();
      set_req(2, APPE, 8'd0, 16'd0, 16'd12);
      set_req(3, APPE, 8'd0, 16'd0, 16'd13);
      cycle();
      set_req(1, APPE, 8'd0, 16'd0, 16'd11);
      drain("t2b_drain");
      chk("t2b_n", grant_log.size(), 3);
      if (grant_log.size() == 3) begin
         chk("t2b_g0", grant_log[0], 2);
         chk("t2b_g1", grant_log[1], 3);
         chk("t2b_g2", grant_log[2], 1);
      end

      // READ from requester 2 with result backpressure
      set_req(2, READ, 8'd3, 16'd2, 16'd0);
      rd_delay = 0; rd_data = 16'd112; rb = 4'b0100;
      cycle(); cycle();
      for (int k = 0; k < 3; k++) begin
         cyc_pre();
         chk("t3_rv_held", resp_valid, 4'b0100);
         chk("t3_dbusy", lnk_if.dout_busy, 1'b1);
         chk("t3_rdata", resp_data, 16'd112);
         step();
      end
      rb = '0;
      cyc_pre();
      chk("t3_rv_done", resp_valid, 4'b0100);
      chk("t3_dbusy_done", lnk_if.dout_busy, 1'b0);
      step();
      chk("t3_model_idle", m_phase, 0);
      set_req(0, APPE, 8'd0, 16'd0, 16'd5);
      cyc_pre();
      chk("t3_idle_grant", req_busy, 4'b1110);
      step();
      drain("t3_drain");

      // order_busy held during ISSUE
      set_req(1, CHAG, 8'd5, 16'd6, 16'd777);
      set_req(3, DELE, 8'd7, 16'd8, 16'd999);
      ob = 1;
      cycle();
      for (int k = 0; k < 5; k++) begin
         cyc_pre();
         chk("t4_ovalid", lnk_if.order_valid, 1'b1);
         chk("t4_data", lnk_if.order_data, 16'd777);
         chk("t4_type", lnk_if.order_type, 2'b10);
         chk("t4_busy", req_busy, 4'hF);
         step();
      end
      ob = 0;
      drain("t4_drain");

      // unexpected dout in IDLE
      spur = 1;
      cyc_pre();
      chk("t5_dbusy", lnk_if.dout_busy, 1'b0);
      chk("t5_rv", resp_valid, 4'h0);
      step();
      chk("t5_err", err, 1'b1);
      cycle(); cycle(); cycle();
      chk("t5_err_sticky", err, 1'b1);
      rst = 1; cycle(); rst = 0;
      chk("t5_err_clr", err, 1'b0);

      // reset in WAIT_RD
      set_req(0, READ, 8'd1, 16'd1, 16'd0);
      rd_delay = 6; rd_data = 16'hBEEF;
      cycle(); cycle(); cycle();
      chk("t6_in_wait", m_phase, 2);
      rst = 1; cycle(); rst = 0;
      chk("t6_ovalid", lnk_if.order_valid, 1'b0);
      chk("t6_busy", req_busy, 4'hF);
      chk("t6_odata", lnk_if.order_data, 16'd0);
      chk("t6_rv", resp_valid, 4'h0);
      chk("t6_ptr", m_ptr, 0);
      set_req(3, APPE, 8'd9, 16'd9, 16'd333);
      cyc_pre();
      chk("t6_grant3", req_busy, 4'b0111);
      step();
      chk("t6_odata3", lnk_if.order_data, 16'd333);
      chk("t6_ovalid3", lnk_if.order_valid, 1'b1);
      drain("t6_drain");

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!p_v[i] && $urandom_range(0, 3) == 0)
               set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom), 16'($urandom));
         ob = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) rb[i] = ($urandom_range(0, 2) == 0);
         rd_delay = $urandom_range(0, 3);
         rd_data  = 16'($urandom);
         spur = (!lk_pend && m_phase != 2 && $urandom_range(0, 49) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         cycle();
         rst = 0;
      end
      rb = '0; ob = 0;
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/link_order_arbiter.md
Name: link_order_arbiter

Overview:
- Shares the single order port of link_top (linked-list table engine) among NUM_REQ requesters with round-robin arbitration.
- Serialises orders: one order in flight at a time.
- Routes READ results arriving on link_top's dout port back to the requester that issued the READ.
- Sits between the requester clients and link_top; uses the same valid/busy handshake on all sides.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- ADDR_WIDTH, 16, node address width (matches link_top).
- DATA_WIDTH, 16, node data width (matches link_top).
- TABLE_WIDTH, 8, table index width (matches link_top).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester order valid.
- req_busy  out  NUM_REQ  per-requester backpressure.
- req_type  in  2*NUM_REQ  per-requester order type, packed, requester i at [2i+1:2i].
- req_table  in  TABLE_WIDTH*NUM_REQ  per-requester table index, packed.
- req_node  in  ADDR_WIDTH*NUM_REQ  per-requester node position, packed.
- req_data  in  DATA_WIDTH*NUM_REQ  per-requester data, packed.
- resp_valid  out  NUM_REQ  read-result valid, one-hot.
- resp_busy  in  NUM_REQ  per-requester result backpressure.
- resp_data  out  DATA_WIDTH  read result, shared by all requesters.
- order_valid  out  1  to link_top.
- order_busy  in  1  from link_top.
- order_type  out  2  to link_top.
- order_table  out  TABLE_WIDTH  to link_top.
- order_node  out  ADDR_WIDTH  to link_top.
- order_data  out  DATA_WIDTH  to link_top.
- dout_valid  in  1  from link_top.
- dout_busy  out  1  to link_top.
- dout_data  in  DATA_WIDTH  from link_top.
- err_unexpected  out  1  sticky flag: dout_valid seen with no READ pending.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where valid=1 and busy=0. Valid and payload are held stable until that edge.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Round-robin grant among the asserted req_valid bits, starting from rr_ptr.
  - req_busy is all-ones except the winner's bit, which is 0. With no request pending, req_busy is all-ones.
  - On that edge: capture the winner's payload into the order_* registers, record grant_idx, set rr_ptr = grant_idx+1 (mod NUM_REQ), go to ISSUE.
- ISSUE:
  - order_valid=1 (registered); payload is held; req_busy is all-ones.
  - On an edge with !order_busy: order_valid←0.
  - If type==READ (2'b11), go to WAIT_RD; otherwise go to IDLE.
- WAIT_RD:
  - Combinational passthrough: resp_valid[grant_idx]=dout_valid, resp_data=dout_data, dout_busy=resp_busy[grant_idx].
  - On an edge with dout_valid && !resp_busy[grant_idx], go to IDLE.
- Latency:
  - Requester accept edge to order_valid high: 1 cycle.
  - Minimum spacing between accepted non-READ orders: 2 cycles, or more if link_top holds order_busy.
- Outside WAIT_RD: resp_valid=0 and dout_busy=0.
  - A dout_valid in these states is consumed and dropped, and err_unexpected is set.
  - err_unexpected clears only on rst.
- CHAG (2'b10) and DELE (2'b01) are forwarded unchanged, the same as APPE (2'b00). The arbiter never decodes table or node.
- Single requester: re-granted every 2 cycles. Fairness is unaffected by rr_ptr skipping idle requesters.
- rst mid-operation (any state): state←IDLE, order_valid←0, rr_ptr←0, grant_idx←0, order_* payload←0, err_unexpected←0.
  - The in-flight order is abandoned. link_top must be reset together with the arbiter.
- Reset values of outputs: req_busy all-ones, order_valid 0, order_type/table/node/data 0, resp_valid 0, resp_data 0 (dout_data ignored outside WAIT_RD and gated to 0), dout_busy 0, err_unexpected 0.

Decomposition:
- Shared package link_pkg:
  - localparams APPE/DELE/CHAG/READ.
  - typedef order_t {type, table, node, data}, parameterised through package widths.
  - enum arb_state_t {IDLE, ISSUE, WAIT_RD}.
- One sub-module, link_rr_arb:
  - Pure round-robin grant (req vector, rr_ptr in; one-hot grant and index out).
  - Combinational only; the pointer register stays in link_order_arbiter.

Test Plan:
- Reset, then requester 0 sends APPE(table 3, node 1, data 111) with order_busy=0 → order_valid high 1 cycle after accept, with type 00, table 3, node 1, data 111. req_busy[0] is 0 only on the accept edge.
- Requesters 0..3 all assert valid simultaneously with APPE data 10,11,12,13 → grants in order 0,1,2,3, one order per 2 cycles. Requester 1 then re-asserts with rr_ptr=0 → still served only after the pending 2,3 (order 2,3,1).
- Requester 2 sends READ(table 3, node 2); link_top returns dout_data=112 with resp_busy[2]=1 for 3 cycles → resp_valid[2] held, dout_busy=1 for 3 cycles, then the transfer completes and the FSM returns to IDLE. resp_valid[0,1,3] stay 0.
- order_busy held 1 for 5 cycles during ISSUE → order_valid and payload stable for 5 cycles; no other requester is accepted.
- dout_valid pulses while in IDLE → dout_busy=0, no resp_valid, err_unexpected=1 until rst.
- rst asserted during WAIT_RD → next edge: all outputs at reset values, rr_ptr=0. A following request from requester 3 is granted normally.
